cu_issue: RTL and testbench

CU_ISSUE -- requirements
Module: cu_issue

---
 rtl/cu_issue.sv | 217 +++++++++++++++++++++
 tb/tb_cu_issue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_issue.sv
// Decode-and-issue buffer: decodes RV32IM fields at push, queues them in a FIFO and issues
// in order, stalling for multi-cycle MUL/DIV occupancy. ALU codes: NO_OP=0 ADD=1 SUB=2 SLL=3
// SLT=4 SLTU=5 XOR=6 SRL=7 SRA=8 OR=9 AND=10 EQU=11 NEQ=12 SGE=13 SGEU=14.
module cu_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode_i,
  input  logic [2:0]               func3_i,
  input  logic [6:0]               func7_i,
  input  logic                     flush_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               ALUctrl_o,
  output logic                     reg_we_o,
  output logic                     op_b_sel_o,
  output logic                     reg1_RE_o,
  output logic                     reg2_RE_o,
  output logic                     mdu_o,
  output logic [2:0]               mdu_op_o,
  output logic                     illegal_o,
  output logic                     mdu_busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned MaxLat = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned LatW   = $clog2(MaxLat + 1);

  localparam logic [LatW-1:0] MulCnt = LatW'(MUL_LAT - 1);
  localparam logic [LatW-1:0] DivCnt = LatW'(DIV_LAT - 1);

  localparam logic [4:0] AluNoOp = 5'd0,  AluAdd = 5'd1,  AluSub = 5'd2,  AluSll = 5'd3;
  localparam logic [4:0] AluSlt  = 5'd4,  AluSltu = 5'd5, AluXor = 5'd6,  AluSrl = 5'd7;
  localparam logic [4:0] AluSra  = 5'd8,  AluOr  = 5'd9,  AluAnd = 5'd10, AluEqu = 5'd11;
  localparam logic [4:0] AluNeq  = 5'd12, AluSge = 5'd13, AluSgeu = 5'd14;

  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpBranch = 7'b1100011, OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;

  typedef struct packed {
    logic [4:0] alu;
    logic       we;
    logic       bsel;
    logic       r1;
    logic       r2;
    logic       mdu;
    logic [2:0] mop;
    logic       ill;
  } entry_t;

  typedef enum logic {StIssue, StMduBusy} state_e;

  function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  entry_t dec;
  entry_t head;
  entry_t mem [DEPTH];

  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] count_q;
  logic [LatW-1:0] cnt_q, cnt_d, lat_cnt;
  state_e          state_q, state_d;
  logic            push, pop;

  always_comb begin
    dec = '0;
    unique case (opcode_i)
      OpLui, OpAuipc, OpJal: begin
        dec.alu = AluAdd; dec.we = 1'b1; dec.bsel = 1'b1;
      end
      OpJalr: begin
        dec.alu = AluAdd; dec.we = 1'b1; dec.bsel = 1'b1; dec.r1 = 1'b1;
        dec.ill = (func3_i != 3'b000);
      end
      OpLoad: begin
        dec.alu = AluAdd; dec.we = 1'b1; dec.bsel = 1'b1; dec.r1 = 1'b1;
        dec.ill = (func3_i == 3'b011) || (func3_i[2:1] == 2'b11);
      end
      OpStore: begin
        dec.alu = AluAdd; dec.bsel = 1'b1; dec.r1 = 1'b1; dec.r2 = 1'b1;
        dec.ill = (func3_i[2] || func3_i == 3'b011);
      end
      OpBranch: begin
        dec.bsel = 1'b1; dec.r1 = 1'b1; dec.r2 = 1'b1;
        case (func3_i)
          3'b000:  dec.alu = AluEqu;
          3'b001:  dec.alu = AluNeq;
          3'b100:  dec.alu = AluSlt;
          3'b101:  dec.alu = AluSge;
          3'b110:  dec.alu = AluSltu;
          3'b111:  dec.alu = AluSgeu;
          default: dec.ill = 1'b1;
        endcase
      end
      OpImm: begin
        dec.we = 1'b1; dec.bsel = 1'b1; dec.r1 = 1'b1;
        // Only the shift-immediates carry func7; SUB has no immediate form.
        dec.alu = alu_f3(func3_i, func3_i == 3'b101 && func7_i[5]);
        if (func3_i == 3'b001) dec.ill = (func7_i != 7'b0000000);
        if (func3_i == 3'b101) dec.ill = (func7_i != 7'b0000000) && (func7_i != 7'b0100000);
      end
      OpReg: begin
        dec.we = 1'b1; dec.r1 = 1'b1; dec.r2 = 1'b1;
        if (func7_i == 7'b0000001) begin
          dec.mdu = 1'b1; dec.mop = func3_i; dec.alu = AluNoOp;
        end else if (func7_i == 7'b0000000) begin
          dec.alu = alu_f3(func3_i, 1'b0);
        end else if (func7_i == 7'b0100000 && (func3_i == 3'b000 || func3_i == 3'b101)) begin
          dec.alu = alu_f3(func3_i, 1'b1);
        end else begin
          dec.ill = 1'b1;
        end
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign in_ready = (count_q < CntW'(DEPTH));
  assign push     = in_valid && in_ready && !flush_i;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= dec;
  end

  assign head    = (count_q != '0) ? mem[rd_q] : '0;
  assign lat_cnt = head.mop[2] ? DivCnt : MulCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIssue;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIssue: begin
        // Single-cycle MDU ops (LAT=1 -> lat_cnt=0) never leave ISSUE.
        if (pop && head.mdu && lat_cnt != '0) begin
          state_d = StMduBusy;
          cnt_d   = lat_cnt;
        end
      end
      StMduBusy: begin
        if (cnt_q <= LatW'(1)) begin
          state_d = StIssue;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LatW'(1);
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == StIssue) && (count_q != '0);
    mdu_busy_o = (state_q == StMduBusy);
  end

  assign count_o    = count_q;
  assign ALUctrl_o  = head.alu;
  assign reg_we_o   = head.we;
  assign op_b_sel_o = head.bsel;
  assign reg1_RE_o  = head.r1;
  assign reg2_RE_o  = head.r2;
  assign mdu_o      = head.mdu;
  assign mdu_op_o   = head.mop;
  assign illegal_o  = head.ill;

endmodule

// File: tb/tb_cu_issue.sv
// Bench for cu_issue: decode vector table plus hand-written FIFO, MDU-stall, flush and
// reset sequences; a scoreboard queue checks every issued head entry in order.
module tb_cu_issue;

  typedef struct packed {
    logic [4:0] alu;
    logic       we;
    logic       bsel;
    logic       r1;
    logic       r2;
    logic       mdu;
    logic [2:0] mop;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    exp_t       e;
  } vec_t;

  localparam logic [4:0] NoOp = 5'd0, Add = 5'd1, Sub = 5'd2, Slt = 5'd4, Sltu = 5'd5;
  localparam logic [4:0] Sra = 5'd8, And = 5'd10, Neq = 5'd12, Sgeu = 5'd14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, flush_i = 1'b0, out_valid, out_ready = 1'b0;
  logic [6:0] opcode_i = '0, func7_i = '0;
  logic [2:0] func3_i = '0;
  logic [4:0] ALUctrl_o;
  logic       reg_we_o, op_b_sel_o, reg1_RE_o, reg2_RE_o, mdu_o, illegal_o, mdu_busy_o;
  logic [2:0] mdu_op_o;
  logic [2:0] count_o;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t vecs[20];
  vec_t div_v;

  cu_issue #(.DEPTH(4), .MUL_LAT(2), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode_i(opcode_i),
    .func3_i(func3_i), .func7_i(func7_i), .flush_i(flush_i), .out_valid(out_valid),
    .out_ready(out_ready), .ALUctrl_o(ALUctrl_o), .reg_we_o(reg_we_o),
    .op_b_sel_o(op_b_sel_o), .reg1_RE_o(reg1_RE_o), .reg2_RE_o(reg2_RE_o), .mdu_o(mdu_o),
    .mdu_op_o(mdu_op_o), .illegal_o(illegal_o), .mdu_busy_o(mdu_busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] alu, input logic [4:0] fl,
                              input logic [2:0] mop, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7;
    v.e = {alu, fl, mop, ill};
    return v;
  endfunction

  function automatic exp_t head_now();
    return {ALUctrl_o, reg_we_o, op_b_sel_o, reg1_RE_o, reg2_RE_o, mdu_o, mdu_op_o, illegal_o};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard: every issue handshake pops and compares the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h expected nothing", head_now());
      end else begin
        exp_t e;
        e = q.pop_front();
        if (head_now() !== e) begin
          errors++;
          $display("FAIL issue_head: got %0h expected %0h", head_now(), e);
        end
      end
    end
  end

  task automatic push(input vec_t v);
    bit ok = 1'b0;
    opcode_i = v.op; func3_i = v.f3; func7_i = v.f7; in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(v.e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_empty(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (count_o == 0 && !mdu_busy_o && q.size() == 0) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = mk(7'b0010011, 3'b000, 7'h00, Add,  5'b11100, 3'b000, 1'b0);
    vecs[1]  = mk(7'b0110011, 3'b011, 7'h00, Sltu, 5'b10110, 3'b000, 1'b0);
    vecs[2]  = mk(7'b1111111, 3'b000, 7'h00, NoOp, 5'b00000, 3'b000, 1'b1);
    vecs[3]  = mk(7'b0010011, 3'b011, 7'h00, Sltu, 5'b11100, 3'b000, 1'b0);
    vecs[4]  = mk(7'b0110011, 3'b000, 7'h20, Sub,  5'b10110, 3'b000, 1'b0);
    vecs[5]  = mk(7'b0010011, 3'b101, 7'h20, Sra,  5'b11100, 3'b000, 1'b0);
    vecs[6]  = mk(7'b1100011, 3'b001, 7'h00, Neq,  5'b01110, 3'b000, 1'b0);
    vecs[7]  = mk(7'b1100011, 3'b111, 7'h00, Sgeu, 5'b01110, 3'b000, 1'b0);
    vecs[8]  = mk(7'b0100011, 3'b010, 7'h00, Add,  5'b01110, 3'b000, 1'b0);
    vecs[9]  = mk(7'b0000011, 3'b010, 7'h00, Add,  5'b11100, 3'b000, 1'b0);
    vecs[10] = mk(7'b0110111, 3'b000, 7'h00, Add,  5'b11000, 3'b000, 1'b0);
    vecs[11] = mk(7'b1101111, 3'b000, 7'h00, Add,  5'b11000, 3'b000, 1'b0);
    vecs[12] = mk(7'b1100111, 3'b000, 7'h00, Add,  5'b11100, 3'b000, 1'b0);
    vecs[13] = mk(7'b0110011, 3'b000, 7'h01, NoOp, 5'b10111, 3'b000, 1'b0);
    vecs[14] = mk(7'b0110011, 3'b000, 7'h02, NoOp, 5'b00000, 3'b000, 1'b1);
    vecs[15] = mk(7'b0110011, 3'b010, 7'h00, Slt,  5'b10110, 3'b000, 1'b0);
    vecs[16] = mk(7'b0110011, 3'b111, 7'h00, And,  5'b10110, 3'b000, 1'b0);
    vecs[17] = mk(7'b0010011, 3'b010, 7'h00, Slt,  5'b11100, 3'b000, 1'b0);
    vecs[18] = mk(7'b1100011, 3'b010, 7'h00, NoOp, 5'b00000, 3'b000, 1'b1);
    vecs[19] = mk(7'b0110011, 3'b011, 7'h01, NoOp, 5'b10111, 3'b011, 1'b0);
    div_v    = mk(7'b0110011, 3'b100, 7'h01, NoOp, 5'b10111, 3'b100, 1'b0);

    #12;
    chk("reset_flags", {in_ready, out_valid, mdu_busy_o}, 3'b100);
    chk("reset_count", count_o, 0);
    chk("reset_head", head_now(), 0);
    tick();
    rst = 1'b0;
    tick();

    // Decode table, issued as fast as the DUT allows.
    out_ready = 1'b1;
    foreach (vecs[i]) push(vecs[i]);
    in_valid = 1'b0;
    wait_empty("decode_drain");
    chk("empty_head", {out_valid, head_now()}, 0);

    // Fill, then pop, then push+pop together, checking count and order.
    out_ready = 1'b0;
    push(vecs[1]); push(vecs[4]); push(vecs[6]); push(vecs[9]);
    in_valid = 1'b0;
    chk("full_count", count_o, 4);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_count", count_o, 3);
    out_ready = 1'b1;
    push(vecs[15]);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pushpop_count", count_o, 3);
    out_ready = 1'b1;
    wait_empty("order_drain");

    // DIV occupancy: 7 busy cycles, the following ADDI issues in the 8th.
    out_ready = 1'b0;
    push(div_v); push(vecs[0]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("div_head_valid", out_valid, 1);
    tick();
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("div_busy_c%0d", k), {mdu_busy_o, out_valid}, 2'b10);
      tick();
    end
    chk("div_done_c8", {mdu_busy_o, out_valid}, 2'b01);
    wait_empty("div_drain");

    // Flush during MDU_BUSY with a concurrent push.
    out_ready = 1'b0;
    push(div_v); push(vecs[0]); push(vecs[0]); push(vecs[0]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_pre", {mdu_busy_o, 1'b0, count_o}, {1'b1, 4'd3});
    flush_i = 1'b1;
    opcode_i = vecs[0].op; func3_i = vecs[0].f3; func7_i = vecs[0].f7; in_valid = 1'b1;
    tick();
    flush_i = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_count", count_o, 0);
    chk("flush_busy_c2", mdu_busy_o, 1);
    for (int k = 3; k <= 7; k++) begin
      tick();
      chk($sformatf("flush_busy_c%0d", k), mdu_busy_o, 1);
    end
    tick();
    chk("flush_busy_end", {mdu_busy_o, out_valid}, 2'b00);

    // Asynchronous reset while busy with a full FIFO.
    out_ready = 1'b0;
    push(div_v); push(vecs[0]); push(vecs[3]); push(vecs[5]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(vecs[7]);
    in_valid = 1'b0;
    chk("busy_push_full", {mdu_busy_o, in_ready, count_o}, {1'b1, 1'b0, 3'd4});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {in_ready, out_valid, mdu_busy_o}, 3'b100);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_head", head_now(), 0);
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst", {mdu_busy_o, out_valid, count_o}, 0);

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
